// File: rtl/reset_controller.sv
// Multi-channel open-drain reset pulse generator with a status/mirror LED driver.
// Each channel stretches a level trigger into a minimum-width active-low reset pulse.
module reset_controller #(
    parameter int                  CHANNELS    = 2,
    parameter int                  PULSE_WIDTH = 8_000_000,
    parameter int                  CNT_W       = 32,
    parameter logic [CHANNELS-1:0] POR_MASK    = '0,
    parameter int                  FAST_BIT    = 22,
    parameter int                  SLOW_BIT    = 26,
    parameter int                  BLINK_BIT   = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] drive_low,
    input  logic [7:0]          led_mode,
    input  logic                pll_ready,
    input  logic                resync,
    input  logic                force_generate,
    input  logic                adv_ready,
    output logic                led_out,
    output logic                led_oe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_WIDTH - 1);

    typedef enum logic {IDLE, ASSERT} ch_state_t;

    // Triangle-wave PWM: phase ramps up then down across each fc[b] half-period.
    function automatic logic glow(input logic [31:0] f, input int b);
        logic [7:0] phase;
        logic [7:0] level;
        phase = f[b-1 -: 8];
        level = f[b] ? ~phase : phase;
        return level > f[7:0];
    endfunction

    logic        por_pend;
    logic [31:0] fc;

    // por_pend is high for exactly the first edge after reset is released
    always_ff @(posedge clock) begin
        if (reset) begin
            por_pend <= 1'b1;
            fc       <= '0;
        end else begin
            por_pend <= 1'b0;
            fc       <= fc + 32'd1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_state_t        state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             dl, dl_nxt;
        logic             req;

        assign req          = trigger[i] | (por_pend & POR_MASK[i]);
        assign drive_low[i] = dl;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            dl_nxt    = dl;
            if (req) begin
                state_nxt = ASSERT;
                cnt_nxt   = '0;
                dl_nxt    = 1'b1;
            end else if (state == ASSERT) begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    dl_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                dl    <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                dl    <= dl_nxt;
            end
        end
    end

    logic glow_fast, glow_slow, blink;
    logic led_out_p0, led_oe_p0;

    assign glow_fast = glow(fc, FAST_BIT);
    assign glow_slow = glow(fc, SLOW_BIT);
    assign blink     = fc[BLINK_BIT];

    always_comb begin
        led_out_p0 = 1'b1;
        led_oe_p0  = 1'b0;
        if (led_mode == 8'd0) begin
            led_oe_p0 = 1'b1;
            if (!pll_ready)          led_out_p0 = 1'b1;
            else if (resync)         led_out_p0 = ~glow_fast;
            else if (force_generate) led_out_p0 = blink ? ~glow_fast : 1'b1;
            else if (adv_ready)      led_out_p0 = 1'b0;
            else                     led_out_p0 = ~glow_slow;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (led_mode == 8'(k + 1)) begin
                    led_out_p0 = 1'b0;
                    led_oe_p0  = drive_low[k];
                end
            end
        end
    end

    // LED register stage
    always_ff @(posedge clock) begin
        if (reset) begin
            led_out <= 1'b1;
            led_oe  <= 1'b0;
        end else begin
            led_out <= led_out_p0;
            led_oe  <= led_oe_p0;
        end
    end

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: table-driven per-cycle vectors through a scoreboard queue,
// plus a long status-mode run against a free-running-counter LED model.
module tb_reset_controller;

    localparam int CH = 2;
    localparam logic [3:0] ST = 4'b1000; // {pll_ready, resync, force_generate, adv_ready}

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] trigger;
    logic [7:0]    led_mode;
    logic          pll_ready, resync, force_generate, adv_ready;
    logic [CH-1:0] drive_low, drive_low_p;
    logic          led_out, led_oe, led_out_p, led_oe_p;

    always #5 clock = ~clock;

    reset_controller #(
        .CHANNELS(CH), .PULSE_WIDTH(4), .CNT_W(32), .POR_MASK(2'b00),
        .FAST_BIT(8), .SLOW_BIT(10), .BLINK_BIT(9)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .drive_low(drive_low),
        .led_mode(led_mode), .pll_ready(pll_ready), .resync(resync),
        .force_generate(force_generate), .adv_ready(adv_ready),
        .led_out(led_out), .led_oe(led_oe)
    );

    reset_controller #(
        .CHANNELS(CH), .PULSE_WIDTH(4), .CNT_W(32), .POR_MASK(2'b10),
        .FAST_BIT(8), .SLOW_BIT(10), .BLINK_BIT(9)
    ) dut_por (
        .clock(clock), .reset(reset), .trigger(trigger), .drive_low(drive_low_p),
        .led_mode(led_mode), .pll_ready(pll_ready), .resync(resync),
        .force_generate(force_generate), .adv_ready(adv_ready),
        .led_out(led_out_p), .led_oe(led_oe_p)
    );

    typedef struct {
        logic          rst;
        logic [CH-1:0] trig;
        logic [7:0]    mode;
        logic [3:0]    st;
        logic [CH-1:0] dl;
        logic [CH-1:0] pdl;
        logic          chk_p;
        logic          chk_dl;
        logic          lo;
        logic          oe;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   row   = 0;

    task automatic add(input int n, input logic rst, input logic [CH-1:0] trig,
                       input logic [7:0] mode, input logic [3:0] st,
                       input logic [CH-1:0] dl, input logic [CH-1:0] pdl,
                       input logic chk_p, input logic lo, input logic oe);
        vec_t v;
        v = '{rst, trig, mode, st, dl, pdl, chk_p, 1'b1, lo, oe};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int r, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, r, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        reset          = v.rst;
        trigger        = v.trig;
        led_mode       = v.mode;
        {pll_ready, resync, force_generate, adv_ready} = v.st;
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (e.chk_dl) check("drive_low", row, 8'(drive_low), 8'(e.dl));
        check("led_out", row, 8'(led_out), 8'(e.lo));
        check("led_oe", row, 8'(led_oe), 8'(e.oe));
        if (e.chk_p) begin
            check("por_drive_low", row, 8'(drive_low_p), 8'(e.pdl));
            check("por_led_out", row, 8'(led_out_p), 8'(e.lo));
            check("por_led_oe", row, 8'(led_oe_p), 8'(e.oe));
        end
        row++;
    endtask

    function automatic logic glow_m(input logic [31:0] f, input int b);
        int unsigned phase, lvl;
        phase = (f >> (b - 8)) % 256;
        lvl   = ((f >> b) % 2 == 1) ? 255 - phase : phase;
        return lvl > (f % 256);
    endfunction

    function automatic logic status_m(input logic [31:0] f, input logic [3:0] st);
        if (!st[3]) return 1'b1;
        if (st[2])  return ~glow_m(f, 8);
        if (st[1])  return ((f >> 9) % 2 == 1) ? ~glow_m(f, 8) : 1'b1;
        if (st[0])  return 1'b0;
        return ~glow_m(f, 10);
    endfunction

    initial begin
        vec_t        v;
        logic [31:0] fc_m;

        // reset; trigger ignored while reset is high
        add(1, 1, 2'b00, 7, ST, 2'b00, 2'b00, 1, 1, 0);
        add(1, 1, 2'b11, 7, ST, 2'b00, 2'b00, 1, 1, 0);
        // release: only the POR_MASK channel of dut_por pulses, for 4 cycles
        add(4, 0, 2'b00, 7, ST, 2'b00, 2'b10, 1, 1, 0);
        add(2, 0, 2'b00, 7, ST, 2'b00, 2'b00, 1, 1, 0);
        // one-cycle trigger on channel 0
        add(1, 0, 2'b01, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(3, 0, 2'b00, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(2, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);
        // retrigger channel 1 mid-pulse restarts the full width
        add(1, 0, 2'b10, 7, ST, 2'b10, 2'b00, 0, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b10, 2'b00, 0, 1, 0);
        add(1, 0, 2'b10, 7, ST, 2'b10, 2'b00, 0, 1, 0);
        add(3, 0, 2'b00, 7, ST, 2'b10, 2'b00, 0, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);
        // trigger held 3 cycles -> 3+4-1 cycles low
        add(3, 0, 2'b01, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(3, 0, 2'b00, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);
        // simultaneous triggers
        add(1, 0, 2'b11, 7, ST, 2'b11, 2'b00, 0, 1, 0);
        add(3, 0, 2'b00, 7, ST, 2'b11, 2'b00, 0, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);
        // mirror channel 1: led_oe lags drive_low[1] by one cycle
        add(1, 0, 2'b10, 2, ST, 2'b10, 2'b00, 0, 0, 0);
        add(3, 0, 2'b00, 2, ST, 2'b10, 2'b00, 0, 0, 1);
        add(1, 0, 2'b00, 2, ST, 2'b00, 2'b00, 0, 0, 1);
        add(1, 0, 2'b00, 2, ST, 2'b00, 2'b00, 0, 0, 0);
        // mirror channel 0, then released LED
        add(1, 0, 2'b01, 1, ST, 2'b01, 2'b00, 0, 0, 0);
        add(1, 0, 2'b00, 1, ST, 2'b01, 2'b00, 0, 0, 1);
        add(2, 0, 2'b00, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);
        // status mode: constant cases
        add(2, 0, 2'b00, 0, 4'b0100, 2'b00, 2'b00, 0, 1, 1);
        add(3, 0, 2'b00, 0, 4'b1001, 2'b00, 2'b00, 0, 0, 1);
        add(1, 0, 2'b00, 0, 4'b0011, 2'b00, 2'b00, 0, 1, 1);
        // reset at cnt=2 kills the pulse; no resume without POR_MASK
        add(1, 0, 2'b01, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(2, 0, 2'b00, 7, ST, 2'b01, 2'b00, 0, 1, 0);
        add(1, 1, 2'b00, 7, ST, 2'b00, 2'b00, 1, 1, 0);
        add(1, 0, 2'b00, 7, ST, 2'b00, 2'b10, 1, 1, 0);
        add(4, 0, 2'b00, 7, ST, 2'b00, 2'b00, 0, 1, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Status-mode LED effects against a free-running counter model
        v = '{1'b1, 2'b00, 8'd0, ST, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        apply(v);
        apply(v);
        fc_m = 32'd0;
        for (int c = 0; c < 2400; c++) begin
            v.rst    = 1'b0;
            v.chk_dl = 1'b0;
            v.st     = (c < 1000) ? 4'b1000 : (c < 1700) ? 4'b1100 : 4'b1010;
            v.lo     = status_m(fc_m, v.st);
            v.oe     = 1'b1;
            apply(v);
            fc_m++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
